// File: rtl/adc_spi_rx.sv
// Purpose : SPI master/deserialiser for a 12-bit AD7476-class ADC (16-bit frame, MSB first).
// Latency : tick in cycle t -> cs_n low at t+1, dato_listo at t+1+CLK_DIV+2*FRAME_BITS*CLK_DIV.
// Backpres: none; every dato_listo strobe must be accepted by the downstream register.
//
// Ports:
//   clk        system clock, all flops on its rising edge
//   reset      synchronous, active-high reset
//   enable     new conversion frames may start while high
//   sdata      ADC serial data, sampled on the rising edge of sclk
//   cs_n       ADC chip select (active low), registered
//   sclk       ADC serial clock, idles high, registered
//   datos      last completed sample, held between strobes
//   dato_listo one-cycle strobe: datos updated this cycle (drives downstream enable)
//   busy       high while a frame is in progress (state other than IDLE)
//
// Build option: define ADC_TWOS_COMP_EN to present the sample as two's complement
// (MSB inverted, offset binary -> signed). Undefined, datos is the raw straight-binary code.

module adc_spi_rx #(
  parameter int DATA_W     = 12,
  parameter int FRAME_BITS = 16,
  parameter int CLK_DIV    = 4,
  parameter int SAMPLE_DIV = 500
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              enable,
  input  logic              sdata,
  output logic              cs_n,
  output logic              sclk,
  output logic [DATA_W-1:0] datos,
  output logic              dato_listo,
  output logic              busy
);

  // ---------------------------------------------------------------------------
  // Elaboration-time parameter sanity
  // ---------------------------------------------------------------------------
  if (CLK_DIV < 1) begin : g_bad_clk_div
    $error("adc_spi_rx: CLK_DIV must be at least 1");
  end
  if (DATA_W < 2 || DATA_W > FRAME_BITS) begin : g_bad_data_w
    $error("adc_spi_rx: DATA_W must be in 2..FRAME_BITS");
  end
  if (SAMPLE_DIV < CLK_DIV * (2 * FRAME_BITS + 2) + 2) begin : g_bad_sample_div
    $error("adc_spi_rx: SAMPLE_DIV too small to fit one full frame per tick");
  end

  localparam int TW = (SAMPLE_DIV > 1) ? $clog2(SAMPLE_DIV) : 1;
  localparam int CW = (CLK_DIV > 1)    ? $clog2(CLK_DIV)    : 1;
  localparam int BW = (FRAME_BITS > 1) ? $clog2(FRAME_BITS) : 1;

  localparam logic [TW-1:0] TICK_LAST = TW'(SAMPLE_DIV - 1);
  localparam logic [CW-1:0] PH_LAST   = CW'(CLK_DIV - 1);
  localparam logic [BW-1:0] BIT_LAST  = BW'(FRAME_BITS - 1);

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    SETUP = 3'd1,
    SHIFT = 3'd2,
    DONE  = 3'd3,
    QUIET = 3'd4
  } state_t;

  // ---------------------------------------------------------------------------
  // State
  // ---------------------------------------------------------------------------
  state_t                  state_q, state_d;
  logic [TW-1:0]           tick_cnt_q;
  logic [CW-1:0]           ph_cnt_q, ph_cnt_d;      // clk cycles within a half-period / phase
  logic                    phase_hi_q, phase_hi_d;  // SHIFT: 0 = sclk low phase, 1 = high phase
  logic [BW-1:0]           bit_cnt_q, bit_cnt_d;    // SHIFT: bit period index
  logic [FRAME_BITS-1:0]   shift_q;
  logic                    cs_n_q, sclk_q;
  logic [DATA_W-1:0]       datos_q;
  logic                    dato_listo_q;

  logic                    tick;
  logic                    ph_last;
  logic                    shift_en;
  logic                    load_en;
  logic                    cs_n_d, sclk_d;
  logic [DATA_W-1:0]       sample_w;
  logic                    unused_lead;

  assign tick    = (tick_cnt_q == TICK_LAST);
  assign ph_last = (ph_cnt_q == PH_LAST);

  // ---------------------------------------------------------------------------
  // Conversion tick: free-running, independent of enable and of the FSM
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk) begin
    if (reset) begin
      tick_cnt_q <= '0;
    end else if (tick) begin
      tick_cnt_q <= '0;
    end else begin
      tick_cnt_q <= tick_cnt_q + TW'(1);
    end
  end

  // ---------------------------------------------------------------------------
  // FSM next-state and output decode
  // cs_n/sclk are decoded from the *next* state so they can be registered and
  // still change in the same cycle the state does (no glitches on the pins).
  // ---------------------------------------------------------------------------
  always_comb begin
    state_d    = state_q;
    ph_cnt_d   = ph_cnt_q;
    phase_hi_d = phase_hi_q;
    bit_cnt_d  = bit_cnt_q;
    shift_en   = 1'b0;

    case (state_q)
      IDLE: begin
        // Ticks outside IDLE are simply lost; they are never queued.
        if (tick && enable) begin
          state_d  = SETUP;
          ph_cnt_d = '0;
        end
      end

      SETUP: begin
        if (ph_last) begin
          state_d    = SHIFT;
          ph_cnt_d   = '0;
          phase_hi_d = 1'b0;
          bit_cnt_d  = '0;
        end else begin
          ph_cnt_d = ph_cnt_q + CW'(1);
        end
      end

      SHIFT: begin
        if (ph_last) begin
          ph_cnt_d = '0;
          if (!phase_hi_q) begin
            // End of low phase: this edge raises sclk, so capture sdata now.
            phase_hi_d = 1'b1;
            shift_en   = 1'b1;
          end else begin
            phase_hi_d = 1'b0;
            if (bit_cnt_q == BIT_LAST) begin
              state_d = DONE;
            end else begin
              bit_cnt_d = bit_cnt_q + BW'(1);
            end
          end
        end else begin
          ph_cnt_d = ph_cnt_q + CW'(1);
        end
      end

      DONE: begin
        state_d  = QUIET;
        ph_cnt_d = '0;
      end

      QUIET: begin
        if (ph_last) begin
          state_d  = IDLE;
          ph_cnt_d = '0;
        end else begin
          ph_cnt_d = ph_cnt_q + CW'(1);
        end
      end

      default: begin
        state_d  = IDLE;
        ph_cnt_d = '0;
      end
    endcase

    cs_n_d  = !((state_d == SETUP) || (state_d == SHIFT));
    sclk_d  = !((state_d == SHIFT) && !phase_hi_d);
    // The last sdata capture happened CLK_DIV cycles before leaving SHIFT,
    // so the shift register is complete when DONE is entered.
    load_en = (state_d == DONE);
  end

  // ---------------------------------------------------------------------------
  // Sample formatting; leading frame bits (always zero from the ADC) are dropped
  // ---------------------------------------------------------------------------
`ifdef ADC_TWOS_COMP_EN
  assign sample_w = {~shift_q[DATA_W-1], shift_q[DATA_W-2:0]};
`else
  assign sample_w = shift_q[DATA_W-1:0];
`endif

  // Oldest frame bit falls off the top of the shift register and is never read.
  assign unused_lead = shift_q[FRAME_BITS-1];

  // ---------------------------------------------------------------------------
  // Sequential state
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q      <= IDLE;
      ph_cnt_q     <= '0;
      phase_hi_q   <= 1'b0;
      bit_cnt_q    <= '0;
      shift_q      <= '0;
      cs_n_q       <= 1'b1;
      sclk_q       <= 1'b1;
      datos_q      <= '0;
      dato_listo_q <= 1'b0;
    end else begin
      state_q      <= state_d;
      ph_cnt_q     <= ph_cnt_d;
      phase_hi_q   <= phase_hi_d;
      bit_cnt_q    <= bit_cnt_d;
      cs_n_q       <= cs_n_d;
      sclk_q       <= sclk_d;
      dato_listo_q <= load_en;
      if (shift_en) begin
        shift_q <= {shift_q[FRAME_BITS-2:0], sdata};
      end
      if (load_en) begin
        datos_q <= sample_w;
      end
    end
  end

  assign cs_n       = cs_n_q;
  assign sclk       = sclk_q;
  assign datos      = datos_q;
  assign dato_listo = dato_listo_q;
  assign busy       = (state_q != IDLE);

endmodule

// File: tb/tb_adc_spi_rx.sv
// Directed bench for adc_spi_rx: default-parameter instance plus a second
// instance running at the minimum legal SAMPLE_DIV, each fed by a small ADC model.
module tb_adc_spi_rx;

  localparam int MIN_DIV = 4 * (2 * 16 + 2) + 2;   // 138

`ifdef ADC_TWOS_COMP_EN
  localparam logic [11:0] E_ABC = 12'h2BC;
  localparam logic [11:0] E_FFF = 12'h7FF;
  localparam logic [11:0] E_001 = 12'h801;
  localparam logic [11:0] E_800 = 12'h000;
  localparam logic [11:0] E_M   = 12'h25C;
`else
  localparam logic [11:0] E_ABC = 12'hABC;
  localparam logic [11:0] E_FFF = 12'hFFF;
  localparam logic [11:0] E_001 = 12'h001;
  localparam logic [11:0] E_800 = 12'h800;
  localparam logic [11:0] E_M   = 12'hA5C;
`endif

  logic        clk = 1'b0;
  logic        reset, enable, sdata;
  logic        cs_n, sclk, dato_listo, busy;
  logic [11:0] datos;
  logic        reset_m, sdata_m;
  logic        cs_n_m, sclk_m, dato_listo_m, busy_m;
  logic [11:0] datos_m;
  logic [11:0] hold_q;

  always #5 clk = ~clk;

  adc_spi_rx dut (
    .clk(clk), .reset(reset), .enable(enable), .sdata(sdata),
    .cs_n(cs_n), .sclk(sclk), .datos(datos), .dato_listo(dato_listo), .busy(busy)
  );

  adc_spi_rx #(.SAMPLE_DIV(MIN_DIV)) dut_min (
    .clk(clk), .reset(reset_m), .enable(1'b1), .sdata(sdata_m),
    .cs_n(cs_n_m), .sclk(sclk_m), .datos(datos_m), .dato_listo(dato_listo_m), .busy(busy_m)
  );

  // Downstream sample-hold register, enabled directly by dato_listo.
  always @(posedge clk) begin
    if (reset) hold_q <= '0;
    else if (dato_listo) hold_q <= datos;
  end

  // ADC models: frame bit k is driven after the k-th falling sclk edge.
  logic [15:0] adc_frame;
  int          adc_k;
  always @(negedge cs_n or negedge sclk) begin
    if (sclk) begin
      adc_k = 0;
      sdata = 1'b0;
    end else if (!cs_n && adc_k < 16) begin
      sdata = adc_frame[15 - adc_k];
      adc_k++;
    end
  end

  logic [15:0] adc_frame_m = 16'h0A5C;
  int          adc_k_m;
  always @(negedge cs_n_m or negedge sclk_m) begin
    if (sclk_m) begin
      adc_k_m = 0;
      sdata_m = 1'b0;
    end else if (!cs_n_m && adc_k_m < 16) begin
      sdata_m = adc_frame_m[15 - adc_k_m];
      adc_k_m++;
    end
  end

  int   checks = 0, errors = 0;
  int   ncyc = 0;
  int   strobes, cs_falls, sclk_rises, cs_low_cyc, sclk_low_cyc, dbl_strobe;
  int   last_cs_fall, last_strobe;
  logic prev_cs = 1'b1, prev_sclk = 1'b1, prev_dl = 1'b0;
  int   m_strobes = 0, m_last = 0, m_first = 0, m_bad_space = 0, m_bad_data = 0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // One clock cycle; outputs are sampled on the falling edge.
  task automatic cyc1();
    @(negedge clk);
    ncyc++;
    if (prev_cs && !cs_n) begin cs_falls++; last_cs_fall = ncyc; end
    if (!cs_n) cs_low_cyc++;
    if (!sclk) sclk_low_cyc++;
    if (!prev_sclk && sclk && !cs_n) sclk_rises++;
    if (dato_listo) begin
      strobes++;
      last_strobe = ncyc;
      if (prev_dl) dbl_strobe++;
    end
    prev_cs   = cs_n;
    prev_sclk = sclk;
    prev_dl   = dato_listo;
    if (dato_listo_m) begin
      if (m_last != 0 && (ncyc - m_last) != MIN_DIV) m_bad_space++;
      if (m_last == 0) m_first = ncyc;
      if (datos_m !== E_M) m_bad_data++;
      m_last = ncyc;
      m_strobes++;
    end
  endtask

  task automatic run_to(input int target);
    while (ncyc < target) cyc1();
  endtask

  task automatic wait_strobe(input int limit);
    int s0;
    s0 = strobes;
    while (strobes == s0 && ncyc < limit) cyc1();
  endtask

  int r0, r2, first2;

  initial begin
    reset = 1'b1; reset_m = 1'b1; enable = 1'b1; sdata = 1'b0; sdata_m = 1'b0;
    adc_frame = 16'h0ABC;
    strobes = 0; cs_falls = 0; sclk_rises = 0; cs_low_cyc = 0; sclk_low_cyc = 0; dbl_strobe = 0;
    last_cs_fall = 0; last_strobe = 0;

    // Reset state
    repeat (3) cyc1();
    chk("rst_cs_n", cs_n, 1);
    chk("rst_sclk", sclk, 1);
    chk("rst_datos", datos, 0);
    chk("rst_dato_listo", dato_listo, 0);
    chk("rst_busy", busy, 0);

    // Frame 0x0ABC: tick at r0+499, cs_n low at r0+500, strobe at r0+632
    reset = 1'b0; reset_m = 1'b0;
    r0 = ncyc;
    strobes = 0; cs_falls = 0; sclk_rises = 0;
    wait_strobe(r0 + 700);
    chk("t1_cs_fall_cyc", last_cs_fall, r0 + 500);
    chk("t1_strobe_cyc", last_strobe, r0 + 632);
    chk("t1_sclk_rises", sclk_rises, 16);
    chk("t1_datos", datos, E_ABC);
    cyc1();
    chk("t1_strobe_one_cycle", dato_listo, 0);
    chk("t1_hold_reg", hold_q, E_ABC);
    chk("t1_busy_quiet", busy, 1);
    run_to(r0 + 637);
    chk("t1_idle_after_quiet", busy, 0);
    chk("t1_single_strobe", strobes, 1);

    // enable low across three tick periods
    enable = 1'b0;
    cs_low_cyc = 0; sclk_low_cyc = 0; strobes = 0;
    run_to(r0 + 2100);
    chk("t2_cs_low_cycles", cs_low_cyc, 0);
    chk("t2_sclk_low_cycles", sclk_low_cyc, 0);
    chk("t2_strobes", strobes, 0);
    chk("t2_datos_held", datos, E_ABC);

    // enable dropped 50 cycles into a 0x0FFF frame
    enable = 1'b1;
    adc_frame = 16'h0FFF;
    strobes = 0; cs_falls = 0;
    run_to(r0 + 2550);
    chk("t3_busy_mid_frame", busy, 1);
    enable = 1'b0;
    wait_strobe(r0 + 2700);
    chk("t3_strobe_cyc", last_strobe, r0 + 2632);
    chk("t3_datos", datos, E_FFF);
    run_to(r0 + 3700);
    chk("t3_strobes", strobes, 1);
    chk("t3_frames_started", cs_falls, 1);

    // reset pulse at tick+40 (tick at r0+3999)
    enable = 1'b1;
    adc_frame = 16'h0123;
    strobes = 0;
    run_to(r0 + 4039);
    chk("t4_cs_low_mid_frame", cs_n, 0);
    chk("t4_sclk_low_mid_frame", sclk, 0);
    reset = 1'b1;
    cyc1();
    chk("t4_cs_n_after_reset", cs_n, 1);
    chk("t4_sclk_after_reset", sclk, 1);
    chk("t4_datos_after_reset", datos, 0);
    chk("t4_busy_after_reset", busy, 0);
    reset = 1'b0;
    r2 = ncyc;

    // back-to-back 0x0001 then 0x0800 through the downstream register
    adc_frame = 16'h0001;
    strobes = 0; cs_falls = 0;
    wait_strobe(r2 + 700);
    chk("t5_cs_fall_cyc", last_cs_fall, r2 + 500);
    chk("t5_first_strobe_cyc", last_strobe, r2 + 632);
    first2 = last_strobe;
    cyc1();
    chk("t5_hold_first", hold_q, E_001);
    adc_frame = 16'h0800;
    wait_strobe(r2 + 1300);
    chk("t5_strobe_spacing", last_strobe - first2, 500);
    cyc1();
    chk("t5_hold_second", hold_q, E_800);
    chk("t5_strobes", strobes, 2);
    chk("t5_no_double_strobe", dbl_strobe, 0);

    // minimum SAMPLE_DIV instance: first tick at r0+137, strobe 133 later
    chk("t6_first_strobe_cyc", m_first, r0 + 270);
    chk("t6_spacing_errors", m_bad_space, 0);
    chk("t6_data_errors", m_bad_data, 0);
    chk("t6_strobe_count", m_strobes, (m_last - (r0 + 270)) / MIN_DIV + 1);
    chk("t6_no_dropped_tail", (ncyc - m_last) < MIN_DIV, 1);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
